// File: rtl/flt2i_result_accum.sv
// Block accumulator for float-to-int converter results: sums a block of signed
// integer beats with saturation, ORs their status flags, and holds the result until taken.
module flt2i_result_accum #(
    parameter int isize     = 32,
    parameter int acc_width = 40,
    parameter int cnt_width = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [cnt_width-1:0] blk_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [isize-1:0]     in_z,
    input  logic [7:0]           in_status,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [acc_width-1:0] out_sum,
    output logic [cnt_width:0]   out_count,
    output logic [7:0]           out_status,
    output logic                 out_sat
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ACC   = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [acc_width-1:0] SUM_MAX = {1'b0, {(acc_width-1){1'b1}}};
    localparam logic [acc_width-1:0] SUM_MIN = {1'b1, {(acc_width-1){1'b0}}};
    localparam logic [cnt_width:0]   CNT_ONE = {{cnt_width{1'b0}}, 1'b1};

    state_t                 r_state, w_state_next;
    logic [acc_width-1:0]   r_sum, w_sum_next;
    logic [cnt_width:0]     r_count, w_count_next;
    logic [cnt_width:0]     r_target, w_target_next;
    logic [7:0]             r_status, w_status_next;
    logic                   r_sat, w_sat_next;

    logic [acc_width:0]     w_z_ext;
    logic [acc_width:0]     w_raw;
    logic                   w_ovf;
    logic [acc_width-1:0]   w_sat_sum;
    logic [cnt_width:0]     w_len_first;
    logic [cnt_width:0]     w_target;
    logic [cnt_width:0]     w_count_inc;
    logic                   w_beat;

    // One guard bit above the accumulator exposes signed overflow of the add.
    assign w_z_ext     = {{(acc_width+1-isize){in_z[isize-1]}}, in_z};
    assign w_raw       = {r_sum[acc_width-1], r_sum} + w_z_ext;
    assign w_ovf       = w_raw[acc_width] ^ w_raw[acc_width-1];
    assign w_sat_sum   = w_ovf ? (w_raw[acc_width] ? SUM_MIN : SUM_MAX)
                               : w_raw[acc_width-1:0];

    // A zero length field encodes the full 2^cnt_width beat block.
    assign w_len_first = (blk_len == '0) ? {1'b1, {cnt_width{1'b0}}}
                                         : {1'b0, blk_len};
    assign w_target    = (r_state == S_EMPTY) ? w_len_first : r_target;
    assign w_count_inc = r_count + CNT_ONE;
    assign w_beat      = in_valid && (r_state != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_EMPTY;
            r_sum    <= '0;
            r_count  <= '0;
            r_target <= '0;
            r_status <= '0;
            r_sat    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_sum    <= w_sum_next;
            r_count  <= w_count_next;
            r_target <= w_target_next;
            r_status <= w_status_next;
            r_sat    <= w_sat_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_sum_next    = r_sum;
        w_count_next  = r_count;
        w_target_next = r_target;
        w_status_next = r_status;
        w_sat_next    = r_sat;

        if (clear) begin
            w_state_next  = S_EMPTY;
            w_sum_next    = '0;
            w_count_next  = '0;
            w_target_next = '0;
            w_status_next = '0;
            w_sat_next    = 1'b0;
        end else begin
            case (r_state)
                S_EMPTY, S_ACC: begin
                    if (w_beat) begin
                        w_sum_next    = w_sat_sum;
                        w_count_next  = w_count_inc;
                        w_target_next = w_target;
                        w_status_next = r_status | in_status;
                        w_sat_next    = r_sat | w_ovf;
                        w_state_next  = (w_count_inc == w_target) ? S_DONE : S_ACC;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        w_state_next  = S_EMPTY;
                        w_sum_next    = '0;
                        w_count_next  = '0;
                        w_target_next = '0;
                        w_status_next = '0;
                        w_sat_next    = 1'b0;
                    end
                end
                default: begin
                    w_state_next = S_EMPTY;
                end
            endcase
        end
    end

    assign in_ready   = (r_state != S_DONE);
    assign out_valid  = (r_state == S_DONE);
    assign out_sum    = r_sum;
    assign out_count  = r_count;
    assign out_status = r_status;
    assign out_sat    = r_sat;

endmodule
